// File: rtl/buck_sim_pkg.sv
// buck_sim_pkg: solver state type, default coefficients and the shared
// fixed-point multiply-rescale / saturation helpers.
package buck_sim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CURR = 2'd1,
        VOLT = 2'd2
    } state_t;

    localparam logic [31:0] DEF_K_TL  = 32'h0000_0083;
    localparam logic [31:0] DEF_K_4CT = 32'h0002_0000;
    localparam logic [31:0] DEF_K_G   = 32'h0000_E884;
    localparam logic [31:0] DEF_K_E   = 32'h0000_003B;

    // Wide enough for any DATA_W up to 64 to hold a full product.
    localparam int XW = 128;
    typedef logic signed [XW-1:0] wide_t;

    function automatic wide_t mul_rs(input wide_t a, input wide_t b,
                                     input int frac);
        wide_t p;
        p = a * b;
        return p >>> frac;
    endfunction

    function automatic wide_t lim_of(input int w);
        return wide_t'(1) <<< (w - 1);
    endfunction

    function automatic logic fits(input wide_t x, input int w);
        return (x < lim_of(w)) && (x >= -lim_of(w));
    endfunction

    function automatic wide_t sat_fit(input wide_t x, input int w);
        if (x >= lim_of(w))
            return lim_of(w) - 1;
        if (x < -lim_of(w))
            return -lim_of(w);
        return x;
    endfunction

    function automatic wide_t sat_add(input wide_t a, input wide_t b,
                                      input int w);
        return sat_fit(a + b, w);
    endfunction

endpackage

// File: rtl/buck_sim_pwm.sv
// buck_sim_pwm: per-timestep PWM counter with duty latched at count 0.
module buck_sim_pwm #(
    parameter int PWM_W      = 10,
    parameter int PWM_PERIOD = 200
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             latch_i,
    input  logic             adv_i,
    input  logic [PWM_W-1:0] duty_i,
    output logic             sw_o
);

    localparam logic [PWM_W-1:0] LAST = PWM_W'(PWM_PERIOD - 1);

    logic [PWM_W-1:0] cnt;
    logic [PWM_W-1:0] duty_q;
    logic [PWM_W-1:0] duty_eff;

    // At count 0 the freshly latched duty already governs this step.
    always_comb begin
        duty_eff = (cnt == '0) ? duty_i : duty_q;
        sw_o     = cnt < duty_eff;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt    <= '0;
            duty_q <= '0;
        end else begin
            if (latch_i && cnt == '0)
                duty_q <= duty_i;
            if (adv_i)
                cnt <= (cnt == LAST) ? '0 : cnt + PWM_W'(1);
        end
    end

endmodule

// File: rtl/buck_sim_core.sv
// buck_sim_core: two-phase trapezoidal solver for an ideal buck converter.
// Define BUCK_SIM_SAT_EN for clamping arithmetic with a sticky sat_o flag.
module buck_sim_core
    import buck_sim_pkg::*;
#(
    parameter int                       DATA_W     = 32,
    parameter int                       FRAC_W     = 16,
    parameter int                       PWM_W      = 10,
    parameter int                       PWM_PERIOD = 200,
    parameter logic signed [DATA_W-1:0] K_TL       = DEF_K_TL,
    parameter logic signed [DATA_W-1:0] K_4CT      = DEF_K_4CT,
    parameter logic signed [DATA_W-1:0] K_G        = DEF_K_G,
    parameter logic signed [DATA_W-1:0] K_E        = DEF_K_E
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              run_i,
    input  logic [DATA_W-1:0] vin_i,
    input  logic [PWM_W-1:0]  duty_i,
    output logic [DATA_W-1:0] v_out_o,
    output logic [DATA_W-1:0] i_l_o,
    output logic              sw_o,
    output logic              valid_o,
    output logic              sat_o
);

    typedef logic signed [DATA_W-1:0] fx_t;

    function automatic wide_t ext(input fx_t x);
        return wide_t'(x);
    endfunction

    function automatic fx_t fit(input wide_t x);
`ifdef BUCK_SIM_SAT_EN
        wide_t y;
        y = sat_fit(x, DATA_W);
        return y[DATA_W-1:0];
`else
        return x[DATA_W-1:0];
`endif
    endfunction

    state_t state;
    fx_t    i_l, i_c, v2, v1_q;
    logic   sw;

    buck_sim_pwm #(
        .PWM_W      (PWM_W),
        .PWM_PERIOD (PWM_PERIOD)
    ) u_pwm (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .latch_i (state == CURR),
        .adv_i   (state == VOLT),
        .duty_i  (duty_i),
        .sw_o    (sw)
    );

    wide_t w_d, w_tl, w_il, w_4ct, w_ic;
    wide_t w_lc, w_g, w_e, w_v2;
    fx_t   v1, d, p_tl, i_l_nx, p_4ct, i_c_nx;
    fx_t   s_lc, p_g, p_e, v2_nx;

    always_comb begin
        v1     = sw ? vin_i : '0;
        w_d    = ext(v1) - ext(v2);
        d      = fit(w_d);
        w_tl   = mul_rs(ext(d), ext(K_TL), FRAC_W);
        p_tl   = fit(w_tl);
        w_il   = ext(i_l) + ext(p_tl);
        i_l_nx = fit(w_il);
        w_4ct  = mul_rs(ext(v2), ext(K_4CT), FRAC_W);
        p_4ct  = fit(w_4ct);
        w_ic   = ext(p_4ct) - ext(i_c);
        i_c_nx = fit(w_ic);
        // VOLT sees the i_l/i_c just committed in CURR.
        w_lc   = ext(i_l) + ext(i_c);
        s_lc   = fit(w_lc);
        w_g    = mul_rs(ext(s_lc), ext(K_G), FRAC_W);
        p_g    = fit(w_g);
        w_e    = mul_rs(ext(v1_q), ext(K_E), FRAC_W);
        p_e    = fit(w_e);
        w_v2   = ext(p_g) + ext(p_e);
        v2_nx  = fit(w_v2);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            i_l     <= '0;
            i_c     <= '0;
            v2      <= '0;
            v1_q    <= '0;
            v_out_o <= '0;
            i_l_o   <= '0;
            sw_o    <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (run_i)
                        state <= CURR;
                end
                CURR: begin
                    i_l   <= i_l_nx;
                    i_c   <= i_c_nx;
                    v1_q  <= v1;
                    sw_o  <= sw;
                    state <= VOLT;
                end
                VOLT: begin
                    v2      <= v2_nx;
                    v_out_o <= v2_nx;
                    i_l_o   <= i_l;
                    valid_o <= 1'b1;
                    state   <= run_i ? CURR : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BUCK_SIM_SAT_EN
    logic sat_q, ovf_c, ovf_v;

    always_comb begin
        ovf_c = !fits(w_d, DATA_W) || !fits(w_tl, DATA_W)
             || !fits(w_il, DATA_W) || !fits(w_4ct, DATA_W)
             || !fits(w_ic, DATA_W);
        ovf_v = !fits(w_lc, DATA_W) || !fits(w_g, DATA_W)
             || !fits(w_e, DATA_W) || !fits(w_v2, DATA_W);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            sat_q <= 1'b0;
        else if ((state == CURR && ovf_c) || (state == VOLT && ovf_v))
            sat_q <= 1'b1;
    end

    assign sat_o = sat_q;
`else
    assign sat_o = 1'b0;
`endif

endmodule
